// File: rtl/wb_arbiter_pkg.sv
// Shared back-end types for the write-back arbiter: tag widths, unit indices, broadcast entry.
// The WB_BR_PRIORITY_EN macro is consumed by wb_arbiter, not by this package.
package rv32i_types;
  localparam int ARCH_REG_BITS = 5;
  localparam int PRD_BITS      = 6;
  localparam int NUM_REQ_DEF   = 5;

  localparam int UNIT_ADD = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_DIV = 2;
  localparam int UNIT_MEM = 3;
  localparam int UNIT_BR  = 4;

  typedef struct packed {
    logic [PRD_BITS-1:0]      prd;
    logic [ARCH_REG_BITS-1:0] ard;
    logic [31:0]              data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Functional-unit result channels and the single CDB broadcast port of the write-back arbiter.
interface wb_arbiter_if #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_REQ       = 5
) ();
  import rv32i_types::*;

  localparam int SRC_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ-1:0]                     req_ready;
  logic [NUM_REQ-1:0][PHYS_REG_BITS-1:0]  req_prd;
  logic [NUM_REQ-1:0][ARCH_REG_BITS-1:0]  req_ard;
  logic [NUM_REQ-1:0][31:0]               req_data;

  logic                     wb_we;
  logic [PHYS_REG_BITS-1:0] wb_prd;
  logic [ARCH_REG_BITS-1:0] wb_ard;
  logic [31:0]              wb_data;
  logic [SRC_BITS-1:0]      wb_src;

  modport master (
    output req_valid, req_prd, req_ard, req_data,
    input  req_ready, wb_we, wb_prd, wb_ard, wb_data, wb_src
  );

  modport slave (
    input  req_valid, req_prd, req_ard, req_data,
    output req_ready, wb_we, wb_prd, wb_ard, wb_data, wb_src
  );
endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Round-robin selector: first set request strictly after ptr_i, wrapping; one-hot grant plus index.
module rr_picker #(
  parameter int N        = 5,
  parameter int IDX_BITS = 3
) (
  input  logic [N-1:0]        req_i,
  input  logic [IDX_BITS-1:0] ptr_i,
  output logic [N-1:0]        grant_o,
  output logic [IDX_BITS-1:0] idx_o,
  output logic                valid_o
);

  always_comb begin : pick
    int cand;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_BITS'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding slot per functional unit, round-robin onto a registered CDB.
// Optional macro WB_BR_PRIORITY_EN: an occupied br slot always wins without moving the pointer.
module wb_arbiter
  import rv32i_types::*;
#(
  parameter int PHYS_REG_BITS = PRD_BITS,
  parameter int NUM_REQ       = NUM_REQ_DEF
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  wb_arbiter_if.slave bus
);

  localparam int SRC_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]  slotValidQ, slotValidD;
  wb_entry_t           slotQ [NUM_REQ];
  wb_entry_t           slotD [NUM_REQ];
  logic [SRC_BITS-1:0] ptrQ, ptrD;
  logic                wbWeQ, wbWeD;
  wb_entry_t           wbQ, wbD;
  logic [SRC_BITS-1:0] wbSrcQ, wbSrcD;

  wb_entry_t           incoming [NUM_REQ];
  wb_entry_t           cand [NUM_REQ];
  logic [NUM_REQ-1:0]  reqVec, rrGrant, grant, readyVec;
  logic [SRC_BITS-1:0] rrIdx, winIdx;
  logic                rrValid, anyGrant, brWin;

  // An empty slot lets a fresh result compete in the cycle it arrives, giving 1-cycle latency.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      incoming[i].prd  = PRD_BITS'(bus.req_prd[i]);
      incoming[i].ard  = bus.req_ard[i];
      incoming[i].data = bus.req_data[i];
      cand[i]          = slotValidQ[i] ? slotQ[i] : incoming[i];
    end
  end

  assign reqVec = slotValidQ | bus.req_valid;

  rr_picker #(.N(NUM_REQ), .IDX_BITS(SRC_BITS)) u_picker (
    .req_i   (reqVec),
    .ptr_i   (ptrQ),
    .grant_o (rrGrant),
    .idx_o   (rrIdx),
    .valid_o (rrValid)
  );

`ifdef WB_BR_PRIORITY_EN
  assign brWin = reqVec[UNIT_BR];
`else
  assign brWin = 1'b0;
`endif

  always_comb begin
    grant    = '0;
    winIdx   = rrIdx;
    anyGrant = 1'b0;
    if (!flush) begin
      if (brWin) begin
        grant[UNIT_BR] = 1'b1;
        winIdx         = SRC_BITS'(UNIT_BR);
        anyGrant       = 1'b1;
      end else begin
        grant    = rrGrant;
        anyGrant = rrValid;
      end
    end
  end

  assign readyVec      = ~slotValidQ | grant;
  assign bus.req_ready = readyVec;

  // A bypassed result (empty slot, granted) must not also be parked, or it would broadcast twice.
  always_comb begin
    slotValidD = slotValidQ;
    slotD      = slotQ;
    ptrD       = ptrQ;
    wbWeD      = 1'b0;
    wbD        = wbQ;
    wbSrcD     = wbSrcQ;
    if (flush) begin
      slotValidD = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) slotValidD[i] = 1'b0;
        if (bus.req_valid[i] && readyVec[i] && !(grant[i] && !slotValidQ[i])) begin
          slotValidD[i] = 1'b1;
          slotD[i]      = incoming[i];
        end
      end
      if (anyGrant) begin
        wbD    = cand[winIdx];
        wbWeD  = (cand[winIdx].prd != '0);
        wbSrcD = winIdx;
        if (cand[winIdx].ard == '0) wbD.data = '0;
        if (!brWin) ptrD = winIdx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slotValidQ <= '0;
      ptrQ       <= SRC_BITS'(NUM_REQ - 1);
      wbWeQ      <= 1'b0;
      wbQ        <= '0;
      wbSrcQ     <= '0;
    end else begin
      slotValidQ <= slotValidD;
      ptrQ       <= ptrD;
      wbWeQ      <= wbWeD;
      wbQ        <= wbD;
      wbSrcQ     <= wbSrcD;
    end
  end

  always_ff @(posedge clk) begin
    slotQ <= slotD;
  end

  assign bus.wb_we   = wbWeQ;
  assign bus.wb_prd  = PHYS_REG_BITS'(wbQ.prd);
  assign bus.wb_ard  = wbQ.ard;
  assign bus.wb_data = wbQ.data;
  assign bus.wb_src  = wbSrcQ;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus scoreboard queue, one record per clock cycle.
// Expectations follow WB_BR_PRIORITY_EN when the build defines it.
module tb_wb_arbiter;

  logic clk;
  logic rst;
  logic flush;

  wb_arbiter_if #(.PHYS_REG_BITS(6), .NUM_REQ(5)) bus ();

  wb_arbiter #(.PHYS_REG_BITS(6), .NUM_REQ(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit i receives prd+i and data+i; ard is common to all units in a record.
  typedef struct {
    int          id;
    logic        rst;
    logic        flush;
    logic [4:0]  valid;
    logic [5:0]  prd;
    logic [4:0]  ard;
    logic [31:0] data;
    logic [4:0]  expReady;
    bit          chk;
    logic        expWe;
    logic [5:0]  expPrd;
    logic [31:0] expData;
    logic [2:0]  expSrc;
  } vec_t;

  vec_t vecs [$];
  vec_t expQ [$];
  int   nChecks = 0;
  int   nFail   = 0;
  int   nextId  = 1;
  int   ordA [5];
  int   ordB [5];
  logic [4:0] readyA [5];
  logic [4:0] readyB [5];

  function automatic vec_t mkVec(input logic r, input logic f, input logic [4:0] v,
                                 input logic [5:0] p, input logic [4:0] a, input logic [31:0] d,
                                 input logic [4:0] rdy, input bit c, input logic we,
                                 input logic [5:0] ep, input logic [31:0] ed, input logic [2:0] es);
    vec_t x;
    x.id = nextId; x.rst = r; x.flush = f; x.valid = v; x.prd = p; x.ard = a; x.data = d;
    x.expReady = rdy; x.chk = c; x.expWe = we; x.expPrd = ep; x.expData = ed; x.expSrc = es;
    nextId++;
    return x;
  endfunction

  function automatic vec_t idle(input logic [4:0] rdy, input bit c, input logic we,
                                input logic [5:0] ep, input logic [31:0] ed, input logic [2:0] es);
    return mkVec(1'b0, 1'b0, 5'b0, 6'd0, 5'd0, 32'd0, rdy, c, we, ep, ed, es);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkVal($sformatf("v%0d_we", e.id), 32'(bus.wb_we), 32'(e.expWe));
      if (e.chk) begin
        checkVal($sformatf("v%0d_prd", e.id), 32'(bus.wb_prd), 32'(e.expPrd));
        checkVal($sformatf("v%0d_data", e.id), bus.wb_data, e.expData);
        checkVal($sformatf("v%0d_src", e.id), 32'(bus.wb_src), 32'(e.expSrc));
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    checkOutput();
    rst           = v.rst;
    flush         = v.flush;
    bus.req_valid = v.valid;
    for (int i = 0; i < 5; i++) begin
      bus.req_prd[i]  = v.prd + 6'(i);
      bus.req_ard[i]  = v.ard;
      bus.req_data[i] = v.data + 32'(i);
    end
    #1;
    checkVal($sformatf("v%0d_ready", v.id), 32'(bus.req_ready), 32'(v.expReady));
    expQ.push_back(v);
  endtask

  task automatic fillTable();
`ifdef WB_BR_PRIORITY_EN
    ordA   = '{4, 1, 2, 3, 0};
    readyA = '{5'b11111, 5'b10010, 5'b10110, 5'b11110, 5'b11111};
    ordB   = '{4, 3, 0, 1, 2};
`else
    ordA   = '{0, 1, 2, 3, 4};
    readyA = '{5'b11111, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    ordB   = '{3, 4, 0, 1, 2};
`endif
    readyB = '{5'b11111, 5'b11000, 5'b11001, 5'b11011, 5'b11111};

    vecs.push_back(mkVec(0, 0, 5'b00001, 6'd5, 5'd3, 32'h1234, 5'b11111, 1, 1, 6'd5, 32'h1234, 3'd0));
    vecs.push_back(mkVec(0, 0, 5'b10000, 6'd20, 5'd2, 32'h50, 5'b11111, 1, 1, 6'd24, 32'h54, 3'd4));
    vecs.push_back(idle(5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));
    // All five units at once: drains one per cycle in pointer order.
    vecs.push_back(mkVec(0, 0, 5'b11111, 6'd16, 5'd7, 32'h100, readyA[0], 1, 1,
                         6'(16 + ordA[0]), 32'(32'h100 + ordA[0]), 3'(ordA[0])));
    for (int k = 1; k < 5; k++)
      vecs.push_back(idle(readyA[k], 1, 1, 6'(16 + ordA[k]), 32'(32'h100 + ordA[k]), 3'(ordA[k])));
    vecs.push_back(idle(5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));
    vecs.push_back(mkVec(0, 0, 5'b01000, 6'd6, 5'd0, 32'hDEAA, 5'b11111, 1, 1, 6'd9, 32'h0, 3'd3));
    vecs.push_back(mkVec(0, 0, 5'b00001, 6'd0, 5'd4, 32'h77, 5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));
    vecs.push_back(idle(5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));
    // Slot 1 granted and refilled with prd 12 in the same cycle.
    vecs.push_back(mkVec(0, 0, 5'b00011, 6'd20, 5'd1, 32'h300, 5'b11111, 1, 1, 6'd21, 32'h301, 3'd1));
    vecs.push_back(mkVec(0, 0, 5'b00010, 6'd21, 5'd1, 32'h310, 5'b11111, 1, 1, 6'd20, 32'h300, 3'd0));
    vecs.push_back(mkVec(0, 0, 5'b00010, 6'd11, 5'd1, 32'h400, 5'b11111, 1, 1, 6'd22, 32'h311, 3'd1));
    vecs.push_back(idle(5'b11111, 1, 1, 6'd12, 32'h401, 3'd1));
    vecs.push_back(idle(5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));
    // Three slots parked, then flush with a br result presented in the same cycle.
    vecs.push_back(mkVec(0, 0, 5'b01111, 6'd30, 5'd2, 32'h500, 5'b11111, 1, 1, 6'd32, 32'h502, 3'd2));
    vecs.push_back(mkVec(0, 1, 5'b10000, 6'd40, 5'd2, 32'h900, 5'b10100, 0, 0, 6'd0, 32'd0, 3'd0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(idle(5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));
    vecs.push_back(mkVec(0, 0, 5'b11111, 6'd50, 5'd5, 32'h600, readyB[0], 1, 1,
                         6'(50 + ordB[0]), 32'(32'h600 + ordB[0]), 3'(ordB[0])));
    for (int k = 1; k < 5; k++)
      vecs.push_back(idle(readyB[k], 1, 1, 6'(50 + ordB[k]), 32'(32'h600 + ordB[k]), 3'(ordB[k])));
    vecs.push_back(idle(5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));
    // Reset beats flush and handshakes; afterwards add must win over mem (pointer back to 4).
    vecs.push_back(mkVec(1, 1, 5'b11111, 6'd60, 5'd1, 32'h700, 5'b11111, 1, 0, 6'd0, 32'd0, 3'd0));
    vecs.push_back(mkVec(0, 0, 5'b01001, 6'd60, 5'd1, 32'h700, 5'b11111, 1, 1, 6'd60, 32'h700, 3'd0));
    vecs.push_back(idle(5'b11111, 1, 1, 6'd63, 32'h703, 3'd3));
    vecs.push_back(idle(5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstSrc;
    int secondSrc;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.req_prd   = '0;
    bus.req_ard   = '0;
    bus.req_data  = '0;
    fillTable();

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("reset_we", 32'(bus.wb_we), 32'd0);
    checkVal("reset_prd", 32'(bus.wb_prd), 32'd0);
    checkVal("reset_ard", 32'(bus.wb_ard), 32'd0);
    checkVal("reset_data", bus.wb_data, 32'd0);
    checkVal("reset_src", 32'(bus.wb_src), 32'd0);
    checkVal("reset_ready", 32'(bus.req_ready), 32'h1F);

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // add and br together with the pointer parked on br.
`ifdef WB_BR_PRIORITY_EN
    firstSrc  = 4;
    secondSrc = 0;
`else
    firstSrc  = 0;
    secondSrc = 4;
`endif
    applyStimulus(mkVec(0, 0, 5'b10000, 6'd2, 5'd1, 32'h10, 5'b11111, 1, 1, 6'd6, 32'h14, 3'd4));
    applyStimulus(mkVec(0, 0, 5'b10001, 6'd40, 5'd1, 32'h800, 5'b11111, 1, 1,
                        6'(40 + firstSrc), 32'(32'h800 + firstSrc), 3'(firstSrc)));
    applyStimulus(idle(5'b11111, 1, 1, 6'(40 + secondSrc), 32'(32'h800 + secondSrc), 3'(secondSrc)));
    applyStimulus(idle(5'b11111, 0, 0, 6'd0, 32'd0, 3'd0));

    @(negedge clk);
    checkOutput();
    checkVal("queue_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter PHYS_REG_BITS, default 6, width of physical register tags.
REQ-002 Parameter NUM_REQ, default 5, number of functional-unit requesters (index 0 add, 1 mul, 2 div, 3 mem, 4 br).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  pipeline flush; discards all buffered and in-flight results.
REQ-006 req_valid  input  NUM_REQ  per-unit result valid.
REQ-007 req_ready  output  NUM_REQ  per-unit accept; result transfers when valid and ready are both high.
REQ-008 req_prd  input  NUM_REQ x PHYS_REG_BITS  per-unit destination physical tag.
REQ-009 req_ard  input  NUM_REQ x ARCH_REG_BITS  per-unit destination architectural register.
REQ-010 req_data  input  NUM_REQ x 32  per-unit result value.
REQ-011 wb_we, wb_prd, wb_ard, wb_data  output  1/PHYS_REG_BITS/ARCH_REG_BITS/32  single registered write-back/CDB broadcast to regfile, reservation stations, ROB.
REQ-012 wb_src  output  $clog2(NUM_REQ)  index of unit that won the current broadcast.

Function
REQ-013 Each requester SHALL own one holding slot; req_ready[i] SHALL be high iff slot i is empty or being granted this cycle.
REQ-014 Arbitration SHALL pick one occupied slot per cycle, round-robin, starting search at (last winner + 1) mod NUM_REQ.
REQ-015 The winner SHALL appear on wb_* exactly one cycle after grant (registered outputs); end-to-end latency from handshake to wb_we is 1 cycle with no contention.
REQ-016 A slot granted and refilled in the same cycle SHALL hold the new result; no result lost or duplicated.
REQ-017 wb_data SHALL be forced to 0 when the winner's ard equals 0; wb_we SHALL be 0 when the winner's prd equals 0.
REQ-018 No occupied slot: wb_we SHALL deassert next cycle; round-robin pointer unchanged.
REQ-019 All slots full and no grant possible never occurs; one slot always drains per cycle while any is occupied.
REQ-020 flush SHALL empty all slots and deassert wb_we on the following cycle; results presented during flush SHALL be dropped; pointer unchanged.

Reset
REQ-021 On rst: all slots empty, req_ready all high the following cycle, wb_we=0, wb_prd=0, wb_ard=0, wb_data=0, wb_src=0, round-robin pointer=NUM_REQ-1 (first search starts at index 0).
REQ-022 rst SHALL take priority over flush and over any handshake in the same cycle.

Configuration
REQ-023 Macro WB_BR_PRIORITY_EN: when defined, an occupied br slot (index 4) SHALL win unconditionally and SHALL NOT advance the round-robin pointer; when undefined, br participates in plain round-robin.

Structure
REQ-024 ARCH_REG_BITS and a wb_entry_t struct (prd, ard, data) SHALL live in rv32i_types; NUM_REQ default and unit-index constants likewise.
REQ-025 The round-robin selector SHALL be a sub-module rr_picker (request vector, pointer in; one-hot grant, index out).

Verification
REQ-026 Reset then single add result prd=5, ard=3, data=0x1234 -> wb_we=1, wb_prd=5, wb_data=0x1234, wb_src=0 one cycle later.
REQ-027 All five units valid same cycle, pointer=4 -> grants in order 0,1,2,3,4 over five consecutive cycles; ready stays low on waiting units.
REQ-028 mem result ard=0, prd=9, data=0xDEAD -> wb_we=1, wb_prd=9, wb_data=0.
REQ-029 Three slots occupied, flush asserted -> next cycle wb_we=0, all req_ready=1, no later broadcast of flushed tags.
REQ-030 With WB_BR_PRIORITY_EN, add and br valid together, pointer=4 -> br broadcast first, add next; without macro -> add first, br next.
REQ-031 Slot 1 granted while mul presents prd=12 same cycle -> prd=12 broadcast on a later cycle exactly once.
